// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signal bundle between the initiator and the system bus.
// The master modport drives address/control/write data; the slave modport returns data and response.
interface ahb_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: one command at a time, single or INCR burst, pipelined address/data phases,
// wait-state and two-cycle ERROR handling, beat-wise write-data pop and read-data strobe.
module ahb_lite_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [3:0]            cmd_prot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    ahb_lite_master_if.master     bus
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam int         SPAN_W       = LEN_WIDTH + 12;

    typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, ERR1, ERR2} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] addr_left;
    logic [SPAN_W-1:0]    span_end;
    logic                 misaligned;
    logic                 reject;

    // Byte offset just past the burst, relative to the start of its 1KB page.
    always_comb begin
        misaligned = 1'b0;
        case (cmd_size)
            3'd1:    misaligned = cmd_addr[0];
            3'd2:    misaligned = (cmd_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        span_end = SPAN_W'(cmd_addr[9:0])
                 + ((SPAN_W'(cmd_len) + SPAN_W'(1)) << cmd_size[1:0]);
        reject   = (cmd_size > 3'd2) || misaligned || (span_end > SPAN_W'(1024));
    end

    assign cmd_ready = (state == IDLE);
    // Write data is consumed on the edge its address phase completes; the source advances after it.
    assign wr_pop    = bus.HWRITE && bus.HREADY
                    && ((state == ADDR) || ((state == BURST) && !bus.HRESP));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            addr_left  <= '0;
            bus.HADDR  <= '0;
            bus.HTRANS <= TRANS_IDLE;
            bus.HWRITE <= 1'b0;
            bus.HSIZE  <= '0;
            bus.HBURST <= '0;
            bus.HPROT  <= '0;
            bus.HWDATA <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (reject) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            bus.HADDR  <= cmd_addr;
                            bus.HTRANS <= TRANS_NONSEQ;
                            bus.HWRITE <= cmd_write;
                            bus.HSIZE  <= cmd_size;
                            bus.HBURST <= (cmd_len == '0) ? BURST_SINGLE : BURST_INCR;
                            bus.HPROT  <= cmd_prot;
                            addr_left  <= cmd_len;
                            state      <= ADDR;
                        end
                    end
                end
                ADDR, BURST: begin
                    // In BURST the previous beat's data phase overlaps the current address phase.
                    if ((state == BURST) && bus.HRESP) begin
                        bus.HTRANS <= TRANS_IDLE;
                        state      <= bus.HREADY ? ERR2 : ERR1;
                    end else if (bus.HREADY) begin
                        if ((state == BURST) && !bus.HWRITE) begin
                            rd_data  <= bus.HRDATA;
                            rd_valid <= 1'b1;
                        end
                        if (bus.HWRITE)
                            bus.HWDATA <= wr_data;
                        if (addr_left == '0) begin
                            bus.HTRANS <= TRANS_IDLE;
                            state      <= LAST;
                        end else begin
                            bus.HADDR  <= bus.HADDR + (ADDR_WIDTH'(1) << bus.HSIZE);
                            bus.HTRANS <= TRANS_SEQ;
                            addr_left  <= addr_left - LEN_WIDTH'(1);
                            state      <= BURST;
                        end
                    end
                end
                LAST: begin
                    if (bus.HRESP) begin
                        state <= bus.HREADY ? ERR2 : ERR1;
                    end else if (bus.HREADY) begin
                        if (!bus.HWRITE) begin
                            rd_data  <= bus.HRDATA;
                            rd_valid <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                ERR1: begin
                    if (bus.HREADY)
                        state <= ERR2;
                end
                ERR2: begin
                    done  <= 1'b1;
                    err   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a table of zero-wait commands plus hand-written
// sequences for wait states, ERROR response and mid-burst reset.
module tb_ahb_lite_master;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_prot;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;

    ahb_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_prot(cmd_prot),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Slave and source models
    logic [31:0] dp_addr = '0;
    logic        dp_act = 1'b0;
    logic        dp_wr = 1'b0;
    int unsigned pop_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, act_cnt = 0;
    int unsigned pop_mark, rd_mark, wr_mark, done_mark, act_mark;
    logic [31:0] wbase = '0;
    logic [31:0] rd_log [0:255];
    logic [31:0] wr_log [0:255];

    always_comb bus.HRDATA = 32'h11 * (32'(dp_addr[5:2]) + 32'd1);
    always_comb wr_data = wbase + (pop_cnt - pop_mark);

    always @(posedge HCLK) begin
        if (bus.HREADY) begin
            dp_addr <= bus.HADDR;
            dp_act  <= bus.HTRANS[1];
            dp_wr   <= bus.HWRITE;
        end
        if (dp_act && dp_wr && bus.HREADY && !bus.HRESP) begin
            wr_log[wr_cnt[7:0]] <= bus.HWDATA;
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_valid) begin
            rd_log[rd_cnt[7:0]] <= rd_data;
            rd_cnt <= rd_cnt + 1;
        end
        if (wr_pop) pop_cnt <= pop_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.HTRANS != 2'b00) act_cnt <= act_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  len;
        logic        exp_err;
        int unsigned exp_lat;
        int unsigned exp_beats;
        logic [31:0] wb;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mark();
        pop_mark  = pop_cnt;
        rd_mark   = rd_cnt;
        wr_mark   = wr_cnt;
        done_mark = done_cnt;
        act_mark  = act_cnt;
    endtask

    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [3:0] len, input logic [3:0] prot);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len; cmd_prot = prot;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 0;
        for (int unsigned k = 1; k <= 200; k++) begin
            if (done) begin
                lat = k;
                return;
            end
            tick();
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int unsigned lat;
        int unsigned beats;
        wbase = v.wb;
        mark();
        issue(tag, v.wr, v.addr, v.size, v.len, 4'h0);
        wait_done(lat);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " err"}, 32'(err), 32'(v.exp_err));
        chk({tag, " ready_at_done"}, 32'(cmd_ready), 32'd1);
        tick();
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " done_count"}, done_cnt - done_mark, 32'd1);
        chk({tag, " bus_cycles"}, act_cnt - act_mark, v.exp_beats);
        beats = v.wr ? (pop_cnt - pop_mark) : (rd_cnt - rd_mark);
        chk({tag, " beats"}, beats, v.exp_beats);
        if (v.exp_beats != 0) begin
            if (v.wr) begin
                chk({tag, " wr_beats_on_bus"}, wr_cnt - wr_mark, v.exp_beats);
                chk({tag, " first_data"}, wr_log[wr_mark[7:0]], v.exp_first);
                chk({tag, " last_data"}, wr_log[8'(wr_cnt - 1)], v.exp_last);
            end else begin
                chk({tag, " first_data"}, rd_log[rd_mark[7:0]], v.exp_first);
                chk({tag, " last_data"}, rd_log[8'(rd_cnt - 1)], v.exp_last);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        vec_t v;
        //           wr    addr          sz    len    err   lat beats wbase          first          last
        vecs[0] = '{1'b1, 32'h0000_0004, 3'd2, 4'd0,  1'b0, 3,  1,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_1000, 3'd2, 4'd3,  1'b0, 6,  4,  32'h0,         32'h11,        32'h44};
        vecs[2] = '{1'b0, 32'h0000_03FD, 3'd0, 4'd2,  1'b0, 5,  3,  32'h0,         32'h110,       32'h110};
        vecs[3] = '{1'b1, 32'h0000_03FE, 3'd1, 4'd1,  1'b1, 1,  0,  32'h0,         32'h0,         32'h0};
        vecs[4] = '{1'b0, 32'h0000_03F8, 3'd2, 4'd3,  1'b1, 1,  0,  32'h0,         32'h0,         32'h0};
        vecs[5] = '{1'b0, 32'h0000_0002, 3'd2, 4'd0,  1'b1, 1,  0,  32'h0,         32'h0,         32'h0};
        vecs[6] = '{1'b1, 32'h0000_0010, 3'd3, 4'd0,  1'b1, 1,  0,  32'h0,         32'h0,         32'h0};
        vecs[7] = '{1'b1, 32'h0000_0002, 3'd1, 4'd15, 1'b0, 18, 16, 32'h5000_0000, 32'h5000_0000, 32'h5000_000F};
        vecs[8] = '{1'b1, 32'h0000_03F0, 3'd2, 4'd3,  1'b0, 6,  4,  32'h7000_0010, 32'h7000_0010, 32'h7000_0013};
        vecs[9] = '{1'b0, 32'h0000_0001, 3'd1, 4'd0,  1'b1, 1,  0,  32'h0,         32'h0,         32'h0};

        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = '0; cmd_len = '0; cmd_prot = '0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        pop_mark = 0; rd_mark = 0; wr_mark = 0; done_mark = 0; act_mark = 0;
        tick(); tick();

        // Reset state
        chk("rst HTRANS", 32'(bus.HTRANS), 32'd0);
        chk("rst HADDR", bus.HADDR, 32'd0);
        chk("rst HWDATA", bus.HWDATA, 32'd0);
        chk("rst ctrl", {24'd0, bus.HWRITE, bus.HSIZE, bus.HBURST, 1'b0}, 32'd0);
        chk("rst HPROT", 32'(bus.HPROT), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst strobes", {28'd0, wr_pop, rd_valid, done, err}, 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        HRESETn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Single write: bus detail per cycle
        wbase = 32'hDEAD_BEEF;
        mark();
        issue("sw", 1'b1, 32'h4, 3'd2, 4'd0, 4'hA);
        chk("sw HTRANS", 32'(bus.HTRANS), 32'h2);
        chk("sw HADDR", bus.HADDR, 32'h4);
        chk("sw HBURST", 32'(bus.HBURST), 32'h0);
        chk("sw HWRITE", 32'(bus.HWRITE), 32'h1);
        chk("sw HSIZE", 32'(bus.HSIZE), 32'h2);
        chk("sw HPROT", 32'(bus.HPROT), 32'hA);
        chk("sw wr_pop", 32'(wr_pop), 32'h1);
        tick();
        chk("sw HTRANS_dp", 32'(bus.HTRANS), 32'h0);
        chk("sw HWDATA", bus.HWDATA, 32'hDEAD_BEEF);
        chk("sw wr_pop_dp", 32'(wr_pop), 32'h0);
        chk("sw done_early", 32'(done), 32'h0);
        tick();
        chk("sw done", {30'd0, done, err}, 32'h2);
        tick();
        chk("sw pops", pop_cnt - pop_mark, 32'd1);

        // 4-beat write with two wait states on beat 2
        wbase = 32'hC0DE_0000;
        mark();
        issue("ws", 1'b1, 32'h2000, 3'd2, 4'd3, 4'h0);
        chk("ws NONSEQ", {bus.HADDR[29:0], bus.HTRANS}, {30'h2000, 2'b10});
        chk("ws HBURST", 32'(bus.HBURST), 32'h1);
        tick();
        chk("ws beat2 addr", {bus.HADDR[29:0], bus.HTRANS}, {30'h2004, 2'b11});
        chk("ws HWDATA0", bus.HWDATA, 32'hC0DE_0000);
        bus.HREADY = 1'b0;
        #1;
        chk("ws no_pop_wait", 32'(wr_pop), 32'h0);
        for (int w = 0; w < 2; w++) begin
            tick();
            chk($sformatf("ws wait%0d addr", w), {bus.HADDR[29:0], bus.HTRANS}, {30'h2004, 2'b11});
            chk($sformatf("ws wait%0d HWDATA", w), bus.HWDATA, 32'hC0DE_0000);
        end
        bus.HREADY = 1'b1;
        tick();
        chk("ws beat3 addr", {bus.HADDR[29:0], bus.HTRANS}, {30'h2008, 2'b11});
        chk("ws HWDATA1", bus.HWDATA, 32'hC0DE_0001);
        wait_done(lat);
        chk("ws done_seen", 32'(lat != 0), 32'd1);
        chk("ws err", 32'(err), 32'd0);
        tick();
        chk("ws pops", pop_cnt - pop_mark, 32'd4);
        chk("ws done_count", done_cnt - done_mark, 32'd1);
        chk("ws last HWDATA", wr_log[8'(wr_cnt - 1)], 32'hC0DE_0003);

        // 4-beat read, ERROR on beat 2
        mark();
        issue("er", 1'b0, 32'h1000, 3'd2, 4'd3, 4'h0);
        tick();
        chk("er beat2 addr", {bus.HADDR[29:0], bus.HTRANS}, {30'h1004, 2'b11});
        tick();
        chk("er rd beat1", {rd_valid, rd_data[30:0]}, {1'b1, 31'h11});
        bus.HRESP = 1'b1; bus.HREADY = 1'b0;
        tick();
        chk("er HTRANS_idle", 32'(bus.HTRANS), 32'h0);
        chk("er no_rd_err1", 32'(rd_valid), 32'h0);
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 1'b0;
        chk("er no_done_err2", {30'd0, done, rd_valid}, 32'h0);
        tick();
        chk("er done_err", {30'd0, done, err}, 32'h3);
        chk("er ready", 32'(cmd_ready), 32'h1);
        tick();
        chk("er rd_count", rd_cnt - rd_mark, 32'd1);
        chk("er done_count", done_cnt - done_mark, 32'd1);

        // Reset mid-burst, then a normal single read
        mark();
        issue("rs", 1'b0, 32'h1000, 3'd2, 4'd3, 4'h0);
        tick();
        HRESETn = 1'b0;
        #1;
        chk("rs HTRANS", 32'(bus.HTRANS), 32'h0);
        chk("rs ready", 32'(cmd_ready), 32'h1);
        chk("rs HADDR", bus.HADDR, 32'h0);
        tick(); tick();
        HRESETn = 1'b1;
        tick();
        chk("rs no_done", done_cnt - done_mark, 32'd0);
        v = '{1'b0, 32'h1008, 3'd2, 4'd0, 1'b0, 3, 1, 32'h0, 32'h33, 32'h33};
        run_vec("rs_after", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
